// File: rtl/dunc16_mem_arb.sv
// Two-requester arbiter/sequencer for the dunc16 single-port memory (IDLE/ACC/RESP/ACKS).
// Define DUNC16_ARB_RR_EN for round-robin arbitration; default is fixed loader priority.
module dunc16_mem_arb #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_WDATA,
    output logic          CPU_ACK,
    output logic [DW-1:0] CPU_RDATA,
    input  logic          LD_REQ,
    input  logic          LD_WE,
    input  logic [AW-1:0] LD_ADDR,
    input  logic [DW-1:0] LD_WDATA,
    output logic          LD_ACK,
    output logic [DW-1:0] LD_RDATA,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    output logic          MEM_WE,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          OWNER
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_RESP,
        S_ACKS
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          owner_q, owner_d;
    logic          decide;
    logic          win_ld;

`ifdef DUNC16_ARB_RR_EN
    logic          last_ld_q, last_ld_d;

    // On contention the side that lost the previous grant wins.
    always_comb begin
        win_ld    = LD_REQ && (!CPU_REQ || !last_ld_q);
        last_ld_d = decide ? win_ld : last_ld_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) last_ld_q <= 1'b1;
        else       last_ld_q <= last_ld_d;
    end
`else
    always_comb begin
        win_ld = LD_REQ;
    end
`endif

    always_comb begin
        decide = ((state_q == S_IDLE) || (state_q == S_ACKS)) && (CPU_REQ || LD_REQ);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = decide ? S_ACC : S_IDLE;
            S_ACC:   state_d = S_RESP;
            S_RESP:  state_d = S_ACKS;
            S_ACKS:  state_d = decide ? S_ACC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        CPU_ACK = (state_q == S_ACKS) && !owner_q;
        LD_ACK  = (state_q == S_ACKS) && owner_q;
    end

    // Winner's request is latched on the grant edge; MEM_WE is set only for the ACC cycle.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        owner_d     = owner_q;
        rdata_d     = (state_q == S_RESP) ? MEM_RDATA : rdata_q;
        if (decide) begin
            mem_addr_d  = win_ld ? LD_ADDR  : CPU_ADDR;
            mem_wdata_d = win_ld ? LD_WDATA : CPU_WDATA;
            mem_we_d    = win_ld ? LD_WE    : CPU_WE;
            owner_d     = win_ld;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            owner_q     <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rdata_q     <= rdata_d;
            owner_q     <= owner_d;
        end
    end

    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign MEM_WE    = mem_we_q;
    assign OWNER     = owner_q;
    assign CPU_RDATA = rdata_q;
    assign LD_RDATA  = rdata_q;

endmodule

// File: tb/tb_dunc16_mem_arb.sv
// Directed bench for dunc16_mem_arb with a synchronous memory model behind the arbiter.
module tb_dunc16_mem_arb;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CPU_REQ = 1'b0, CPU_WE = 1'b0;
    logic [11:0] CPU_ADDR = '0;
    logic [15:0] CPU_WDATA = '0;
    logic        CPU_ACK;
    logic [15:0] CPU_RDATA;
    logic        LD_REQ = 1'b0, LD_WE = 1'b0;
    logic [11:0] LD_ADDR = '0;
    logic [15:0] LD_WDATA = '0;
    logic        LD_ACK;
    logic [15:0] LD_RDATA;
    logic [11:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic        MEM_WE;
    logic [15:0] MEM_RDATA;
    logic        OWNER;

    logic [15:0] mem [0:4095];
    int          total = 0;
    int          bad = 0;
    logic [3:0]  exp_ld;

    always #5 CLK = ~CLK;

    // Memory macro: write on MEM_WE, read data one cycle after the address.
    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
        MEM_RDATA <= mem[MEM_ADDR];
    end

    dunc16_mem_arb #(.AW(12), .DW(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
        .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
        .LD_ACK(LD_ACK), .LD_RDATA(LD_RDATA),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_RDATA(MEM_RDATA),
        .OWNER(OWNER)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One loader transaction from IDLE, releasing LD_REQ in the ACK cycle.
    task automatic ld_txn(input logic we, input logic [11:0] a, input logic [15:0] d,
                          input logic chk_rd, input logic [15:0] exp_rd);
        LD_REQ = 1'b1; LD_WE = we; LD_ADDR = a; LD_WDATA = d;
        tick();
        chk("ld_acc_we", 32'(MEM_WE), 32'(we));
        chk("ld_acc_addr", 32'(MEM_ADDR), 32'(a));
        if (we) chk("ld_acc_wdata", 32'(MEM_WDATA), 32'(d));
        chk("ld_acc_owner", 32'(OWNER), 32'd1);
        chk("ld_acc_noack", 32'(LD_ACK), 32'd0);
        tick();
        chk("ld_resp_we", 32'(MEM_WE), 32'd0);
        chk("ld_resp_noack", 32'(LD_ACK), 32'd0);
        tick();
        chk("ld_ack", 32'(LD_ACK), 32'd1);
        chk("ld_cpu_ack_low", 32'(CPU_ACK), 32'd0);
        if (chk_rd) chk("ld_rdata", 32'(LD_RDATA), 32'(exp_rd));
        LD_REQ = 1'b0; LD_WE = 1'b0;
        tick();
        chk("ld_ack_single", 32'(LD_ACK), 32'd0);
    endtask

    initial begin
        // Reset values
        tick(); tick();
        RESET = 1'b0;
        chk("rst_mem_we", 32'(MEM_WE), 32'd0);
        chk("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        chk("rst_mem_wdata", 32'(MEM_WDATA), 32'd0);
        chk("rst_cpu_ack", 32'(CPU_ACK), 32'd0);
        chk("rst_ld_ack", 32'(LD_ACK), 32'd0);
        chk("rst_owner", 32'(OWNER), 32'd0);
        chk("rst_rdata", 32'(CPU_RDATA), 32'd0);

        // Loader write then read of 0x005
        ld_txn(1'b1, 12'h005, 16'h1234, 1'b0, 16'h0000);
        ld_txn(1'b0, 12'h005, 16'h0000, 1'b1, 16'h1234);

        // Preload through the loader port
        ld_txn(1'b1, 12'h010, 16'hAAAA, 1'b0, 16'h0000);
        ld_txn(1'b1, 12'h011, 16'h5555, 1'b0, 16'h0000);

        // CPU back-to-back reads, REQ held through the first ACK
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 12'h010;
        tick();
        chk("b2b_acc1_addr", 32'(MEM_ADDR), 32'h010);
        chk("b2b_acc1_owner", 32'(OWNER), 32'd0);
        tick();
        chk("b2b_resp1_ack", 32'(CPU_ACK), 32'd0);
        tick();
        chk("b2b_ack1", 32'(CPU_ACK), 32'd1);
        chk("b2b_ack1_ld", 32'(LD_ACK), 32'd0);
        chk("b2b_rdata1", 32'(CPU_RDATA), 32'hAAAA);
        CPU_ADDR = 12'h011;
        tick();
        chk("b2b_acc2_ack", 32'(CPU_ACK), 32'd0);
        chk("b2b_acc2_addr", 32'(MEM_ADDR), 32'h011);
        tick();
        chk("b2b_resp2_ack", 32'(CPU_ACK), 32'd0);
        tick();
        chk("b2b_ack2", 32'(CPU_ACK), 32'd1);
        chk("b2b_rdata2", 32'(CPU_RDATA), 32'h5555);
        CPU_REQ = 1'b0;
        tick();
        chk("b2b_idle_ack", 32'(CPU_ACK), 32'd0);

        // Abort after grant: CPU_REQ dropped in ACC
        CPU_REQ = 1'b1; CPU_ADDR = 12'h010;
        tick();
        CPU_REQ = 1'b0; CPU_ADDR = 12'h011;
        tick();
        chk("abort_resp_ack", 32'(CPU_ACK), 32'd0);
        tick();
        chk("abort_ack", 32'(CPU_ACK), 32'd1);
        chk("abort_rdata", 32'(CPU_RDATA), 32'hAAAA);
        tick();
        chk("abort_ack_once", 32'(CPU_ACK), 32'd0);
        tick(); tick(); tick();
        chk("abort_idle_ack", 32'(CPU_ACK), 32'd0);
        chk("abort_idle_we", 32'(MEM_WE), 32'd0);
        chk("abort_idle_addr", 32'(MEM_ADDR), 32'h010);

        // Reset for 2 cycles while a loader write is in ACC
        LD_REQ = 1'b1; LD_WE = 1'b1; LD_ADDR = 12'h040; LD_WDATA = 16'hBEEF;
        tick();
        chk("rstmid_acc_we", 32'(MEM_WE), 32'd1);
        chk("rstmid_acc_owner", 32'(OWNER), 32'd1);
        RESET = 1'b1; LD_REQ = 1'b0; LD_WE = 1'b0;
        tick();
        chk("rstmid_we", 32'(MEM_WE), 32'd0);
        chk("rstmid_owner", 32'(OWNER), 32'd0);
        chk("rstmid_addr", 32'(MEM_ADDR), 32'd0);
        chk("rstmid_ld_ack", 32'(LD_ACK), 32'd0);
        tick();
        RESET = 1'b0;
        tick();
        chk("rstmid_post1_ack", 32'(LD_ACK | CPU_ACK), 32'd0);
        tick(); tick();
        chk("rstmid_post3_ack", 32'(LD_ACK | CPU_ACK), 32'd0);
        chk("rstmid_post_we", 32'(MEM_WE), 32'd0);
        chk("rstmid_write_presented", 32'(mem[12'h040]), 32'hBEEF);

        // Contention: both requesters held from IDLE after reset
`ifdef DUNC16_ARB_RR_EN
        exp_ld = 4'b1010;
`else
        exp_ld = 4'b1111;
`endif
        LD_REQ = 1'b1; LD_WE = 1'b0; LD_ADDR = 12'h020;
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 12'h030;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cont_owner", 32'(OWNER), 32'(exp_ld[i]));
            chk("cont_acc_addr", 32'(MEM_ADDR), exp_ld[i] ? 32'h020 : 32'h030);
            tick();
            tick();
            chk("cont_ld_ack", 32'(LD_ACK), 32'(exp_ld[i]));
            chk("cont_cpu_ack", 32'(CPU_ACK), 32'(!exp_ld[i]));
            if (i == 3) LD_REQ = 1'b0;
        end
        tick();
        chk("cont_last_owner", 32'(OWNER), 32'd0);
        tick();
        tick();
        chk("cont_last_cpu_ack", 32'(CPU_ACK), 32'd1);
        chk("cont_last_ld_ack", 32'(LD_ACK), 32'd0);
        CPU_REQ = 1'b0;
        tick();
        chk("cont_done_ack", 32'(LD_ACK | CPU_ACK), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
